// File: rtl/dmux_reg_pkg.sv
// Shared definitions for the registered demultiplexer: default widths and
// the channel-count derivation used by the decoder and the top level.
package dmux_reg_pkg;

    localparam int unsigned BUS_WIDTH_DEF   = 16;
    localparam int unsigned NB_SEL_DEF      = 3;
    localparam int unsigned COUNT_WIDTH_DEF = 8;

    // Number of channels addressed by an nb_sel-bit select.
    function automatic int unsigned nb_out(input int unsigned nb_sel);
        return 32'(1) << nb_sel;
    endfunction

endpackage

// File: rtl/dmux1bit.sv
// One-hot decoder: drives in_i onto the output bit chosen by sel_i.
module dmux1bit
    import dmux_reg_pkg::*;
#(
    parameter int unsigned NB_SEL = NB_SEL_DEF,
    localparam int unsigned NB_OUT = nb_out(NB_SEL)
) (
    input  logic              in_i,
    input  logic [NB_SEL-1:0] sel_i,
    output logic [NB_OUT-1:0] out_c
);

    always_comb begin
        out_c        = '0;
        out_c[sel_i] = in_i;
    end

endmodule

// File: rtl/dmux_reg_slot.sv
// One-entry channel buffer; a slot that is draining this cycle reports free
// so a refill can land on the same edge without a bubble.
module dmux_reg_slot
    import dmux_reg_pkg::*;
#(
    parameter int unsigned WIDTH = BUS_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             free_c
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // Write beats drain; data is left untouched on a pure drain.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (wr_en_i) begin
            data_d  = wr_data_i;
            valid_d = 1'b1;
        end else if (valid_q && rd_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign free_c  = ~valid_q | rd_ready_i;

endmodule

// File: rtl/dmux_reg.sv
// Registered valid/ready demultiplexer: routes each accepted word to one
// channel buffer, or to all of them in broadcast mode, and counts transfers.
module dmux_reg
    import dmux_reg_pkg::*;
#(
    parameter int unsigned BUS_WIDTH   = BUS_WIDTH_DEF,
    parameter int unsigned NB_SEL      = NB_SEL_DEF,
    parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEF,
    localparam int unsigned NB_OUT     = nb_out(NB_SEL)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [BUS_WIDTH-1:0]        in_data,
    input  logic [NB_SEL-1:0]           in_sel,
    input  logic                        in_bcast,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [NB_OUT*BUS_WIDTH-1:0] out_data,
    output logic [NB_OUT-1:0]           out_valid,
    input  logic [NB_OUT-1:0]           out_ready,
    output logic [COUNT_WIDTH-1:0]      in_count
);

    logic [NB_OUT-1:0]      free;
    logic [NB_OUT-1:0]      uni_wr;
    logic [NB_OUT-1:0]      wr_en;
    logic                   accept;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    // Broadcast needs every slot free; unicast only its own target.
    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            in_ready = in_bcast ? (&free) : free[in_sel];
        end
    end

    assign accept = in_valid & in_ready;

    dmux1bit #(
        .NB_SEL (NB_SEL)
    ) u_dec (
        .in_i  (accept & ~in_bcast),
        .sel_i (in_sel),
        .out_c (uni_wr)
    );

    assign wr_en = uni_wr | {NB_OUT{accept & in_bcast}};

    for (genvar k = 0; k < NB_OUT; k++) begin : g_slot
        dmux_reg_slot #(
            .WIDTH (BUS_WIDTH)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .wr_en_i    (wr_en[k]),
            .wr_data_i  (in_data),
            .rd_ready_i (out_ready[k]),
            .data_o     (out_data[k*BUS_WIDTH +: BUS_WIDTH]),
            .valid_o    (out_valid[k]),
            .free_c     (free[k])
        );
    end

    // A broadcast is one transfer; the counter wraps naturally.
    always_comb begin
        count_d = count_q + COUNT_WIDTH'(accept);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign in_count = count_q;

endmodule

// File: tb/tb_dmux_reg.sv
// Bench for dmux_reg: directed vector table, streaming/wrap sequences and
// randomized traffic against a per-channel buffer model.
module tb_dmux_reg;

    localparam int BW  = 4;
    localparam int NS  = 2;
    localparam int NO  = 4;
    localparam int CW  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [BW-1:0]     in_data;
    logic [NS-1:0]     in_sel;
    logic              in_bcast;
    logic              in_valid;
    logic              in_ready;
    logic [NO*BW-1:0]  out_data;
    logic [NO-1:0]     out_valid;
    logic [NO-1:0]     out_ready;
    logic [CW-1:0]     in_count;

    dmux_reg #(
        .BUS_WIDTH   (BW),
        .NB_SEL      (NS),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_count  (in_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one buffer per channel plus a transfer counter.
    logic [NO-1:0] mv;
    logic [BW-1:0] md [NO];
    int            mcnt;
    logic          mrdy;
    logic          rdy_seen;

    typedef struct {
        logic          rst;
        logic          v;
        logic          b;
        logic [NS-1:0] sel;
        logic [BW-1:0] d;
        logic [NO-1:0] ordy;
        logic          e_rdy;
        logic [NO-1:0] e_ov;
        logic [15:0]   e_od;
        logic [CW-1:0] e_cnt;
        logic          all;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] slice_mask(input logic [NO-1:0] v);
        logic [15:0] m = '0;
        for (int k = 0; k < NO; k++) if (v[k]) m[k*BW +: BW] = 4'hF;
        return m;
    endfunction

    // One cycle: drive at the falling edge, sample ready before the rising
    // edge, advance the model on the rising edge, return at the next fall.
    task automatic step(input logic r, input logic v, input logic b,
                        input logic [NS-1:0] s, input logic [BW-1:0] d,
                        input logic [NO-1:0] ordy);
        logic all_free;
        logic acc;
        reset = r; in_valid = v; in_bcast = b; in_sel = s; in_data = d; out_ready = ordy;
        #1;
        rdy_seen = in_ready;
        all_free = 1'b1;
        for (int k = 0; k < NO; k++) if (mv[k] && !ordy[k]) all_free = 1'b0;
        if (r) mrdy = 1'b0;
        else if (b) mrdy = all_free;
        else mrdy = !mv[s] || ordy[s];
        acc = v && mrdy;
        @(posedge clk);
        if (r) begin
            mv = '0;
            for (int k = 0; k < NO; k++) md[k] = '0;
            mcnt = 0;
        end else begin
            for (int k = 0; k < NO; k++) begin
                if (acc && (b || s == NS'(k))) begin
                    mv[k] = 1'b1;
                    md[k] = d;
                end else if (mv[k] && ordy[k]) begin
                    mv[k] = 1'b0;
                end
            end
            if (acc) mcnt = (mcnt + 1) % (1 << CW);
        end
        @(negedge clk);
    endtask

    task automatic model_check(input string tag);
        logic [15:0] exp_od = '0;
        logic [15:0] m = slice_mask(mv);
        for (int k = 0; k < NO; k++) exp_od[k*BW +: BW] = md[k];
        chk({tag, "_ready"}, 32'(rdy_seen), 32'(mrdy));
        chk({tag, "_ovalid"}, 32'(out_valid), 32'(mv));
        chk({tag, "_odata"}, 32'(out_data & m), 32'(exp_od & m));
        chk({tag, "_count"}, 32'(in_count), 32'(mcnt));
    endtask

    vec_t vt [14];

    initial begin
        logic [15:0] m;
        reset = 1'b1; in_valid = 1'b0; in_bcast = 1'b0; in_sel = '0;
        in_data = '0; out_ready = '0;
        mv = '0; mcnt = 0; mrdy = 1'b0; rdy_seen = 1'b0;
        for (int k = 0; k < NO; k++) md[k] = '0;

        //        rst  v    b    sel  d     ordy     rdy  ov       od        cnt  all
        vt[0]  = '{1'b1,1'b0,1'b0,2'd0,4'h0,4'b0000,1'b0,4'b0000,16'h0000,3'd0,1'b1};
        vt[1]  = '{1'b1,1'b0,1'b0,2'd0,4'h0,4'b0000,1'b0,4'b0000,16'h0000,3'd0,1'b1};
        vt[2]  = '{1'b0,1'b1,1'b0,2'd2,4'hA,4'b0000,1'b1,4'b0100,16'h0A00,3'd1,1'b1};
        vt[3]  = '{1'b0,1'b1,1'b0,2'd2,4'hB,4'b0000,1'b0,4'b0100,16'h0A00,3'd1,1'b1};
        vt[4]  = '{1'b0,1'b1,1'b0,2'd1,4'h7,4'b0000,1'b1,4'b0110,16'h0A70,3'd2,1'b1};
        vt[5]  = '{1'b0,1'b1,1'b0,2'd2,4'h5,4'b0100,1'b1,4'b0110,16'h0570,3'd3,1'b1};
        vt[6]  = '{1'b0,1'b1,1'b0,2'd0,4'hC,4'b0000,1'b1,4'b0111,16'h057C,3'd4,1'b1};
        vt[7]  = '{1'b0,1'b1,1'b1,2'd1,4'h3,4'b0000,1'b0,4'b0111,16'h057C,3'd4,1'b1};
        vt[8]  = '{1'b0,1'b1,1'b1,2'd1,4'h3,4'b0111,1'b1,4'b1111,16'h3333,3'd5,1'b1};
        vt[9]  = '{1'b0,1'b0,1'b0,2'd0,4'h0,4'b1111,1'b1,4'b0000,16'h0000,3'd5,1'b0};
        vt[10] = '{1'b0,1'b1,1'b0,2'd0,4'h1,4'b0000,1'b1,4'b0001,16'h0001,3'd6,1'b0};
        vt[11] = '{1'b0,1'b1,1'b0,2'd3,4'h9,4'b0000,1'b1,4'b1001,16'h9001,3'd7,1'b0};
        vt[12] = '{1'b1,1'b1,1'b0,2'd1,4'hF,4'b0000,1'b0,4'b0000,16'h0000,3'd0,1'b1};
        vt[13] = '{1'b0,1'b1,1'b0,2'd0,4'h6,4'b0000,1'b1,4'b0001,16'h0006,3'd1,1'b1};

        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            step(vt[i].rst, vt[i].v, vt[i].b, vt[i].sel, vt[i].d, vt[i].ordy);
            m = vt[i].all ? 16'hFFFF : slice_mask(vt[i].e_ov);
            chk($sformatf("vec%0d_ready", i), 32'(rdy_seen), 32'(vt[i].e_rdy));
            chk($sformatf("vec%0d_ovalid", i), 32'(out_valid), 32'(vt[i].e_ov));
            chk($sformatf("vec%0d_odata", i), 32'(out_data & m), 32'(vt[i].e_od & m));
            chk($sformatf("vec%0d_count", i), 32'(in_count), 32'(vt[i].e_cnt));
        end

        // Back-to-back stream into channel 2 while its consumer drains.
        for (int i = 0; i < 4; i++) begin
            logic [BW-1:0] w = BW'(i + 1);
            step(1'b0, 1'b1, 1'b0, 2'd2, w, 4'b0100);
            chk($sformatf("stream%0d_ready", i), 32'(rdy_seen), 32'd1);
            chk($sformatf("stream%0d_word", i), 32'(out_data[2*BW +: BW]), 32'(w));
            model_check($sformatf("stream%0d", i));
        end

        // Counter wrap: nine accepted transfers on a 3-bit counter.
        step(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 4'b0000);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 1'b0, NS'(i % NO), BW'(i), 4'b1111);
            model_check($sformatf("wrap%0d", i));
        end
        chk("wrap_final_count", 32'(in_count), 32'd1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 40) == 0, 1'($urandom), ($urandom % 6) == 0,
                 NS'($urandom), BW'($urandom), NO'($urandom));
            model_check("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmux_reg.md
Name: dmux_reg

Overview:
- Registered, handshaked successor to the combinational dmux family.
- Routes one BUS_WIDTH-bit word per cycle from a single valid/ready input stream to one of 2**NB_SEL output channels, or to all channels in broadcast mode.
- Each channel holds its word in a one-entry buffer until the consumer takes it.
- Sits between the instruction/data fetch path and the register-file and peripheral write ports. Back-pressure from a busy destination stalls the source instead of losing data.

Parameters:
- BUS_WIDTH, 16, width of each data word.
- NB_SEL, 3, select width; NB_OUT = 2**NB_SEL channels (derived localparam, not overridable).
- COUNT_WIDTH, 8, width of the accepted-transaction counter.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  BUS_WIDTH  word to route.
- in_sel  input  NB_SEL  destination channel index; ignored when in_bcast=1.
- in_bcast  input  1  1 = deliver word to every channel.
- in_valid  input  1  source offers in_data/in_sel/in_bcast this cycle.
- in_ready  output  1  block accepts this cycle; transfer when in_valid & in_ready.
- out_data  output  NB_OUT*BUS_WIDTH  flattened channel buffers; channel k occupies bits [k*BUS_WIDTH +: BUS_WIDTH].
- out_valid  output  NB_OUT  channel k buffer holds an undelivered word.
- out_ready  input  NB_OUT  consumer k takes its word this cycle.
- in_count  output  COUNT_WIDTH  number of accepted transfers, modulo 2**COUNT_WIDTH.

Behaviour:
- Reset: out_valid=0, out_data=0, in_count=0 on the first rising edge with reset=1.
  - While reset=1, in_ready=0 and out_valid stays 0.
  - Reset mid-operation discards all buffered words; no channel presents valid the cycle after reset.
- Slot free[k] = ~out_valid[k] | out_ready[k]. A draining slot counts as free, giving full throughput with no bubble.
- in_ready:
  - in_bcast=0: in_ready = free[in_sel].
  - in_bcast=1: in_ready = AND of free[k] over all k.
  - Combinational from in_sel, in_bcast, out_valid and out_ready; independent of in_valid.
- Accept (in_valid & in_ready & ~reset):
  - Unicast: buffer[in_sel] <= in_data; out_valid[in_sel] <= 1.
  - Broadcast: every buffer <= in_data; every out_valid <= 1.
  - in_count <= in_count + 1. Broadcast counts as one transfer. Wraps from all-ones to 0.
  - Latency: word visible on out_data/out_valid exactly 1 cycle after the accepting edge.
- Channel k, per cycle, in priority order:
  - write to k: load new word, out_valid[k] stays/becomes 1. Simultaneous drain and refill leaves valid=1 with the new data.
  - else out_valid[k] & out_ready[k]: out_valid[k] <= 0. Data register holds its old value and is don't-care.
  - else: hold.
- Not accepted (in_valid=0 or in_ready=0): no state change other than drains. in_sel/in_bcast/in_data are don't-care when in_valid=0.
- out_ready[k] while out_valid[k]=0 has no effect.
- Channels are independent: a stalled channel never blocks unicast traffic to another channel. Broadcast waits until all channels are free.
- No combinational path from in_valid to out_valid/out_data. out_data is driven purely from registers.

Decomposition:
- Shared include (multiplexing defs): NB_OUT derivation macro and the flattened-slice macro (k*BUS_WIDTH +: BUS_WIDTH). The same include is used by the dmux/mux family.
- Sub-module dmux_reg_slot:
  - One-entry channel buffer: clk, reset, wr_en, wr_data, rd_ready → data, valid, free.
  - Instantiated NB_OUT times in a generate loop.
- Write enables come from the existing dmux1bit decoder (NB_SEL) with in = accept & ~in_bcast, OR'd with (accept & in_bcast).

Test Plan:
- Reset then idle; BUS_WIDTH=4, NB_SEL=2: hold reset 2 cycles → out_valid=4'b0000, out_data=16'h0000, in_count=0, in_ready=0 during reset.
- Unicast: in_data=4'hA, in_sel=2, in_valid 1 cycle, out_ready=0 → next cycle out_valid=4'b0100, out_data[11:8]=4'hA, in_count=1. Second offer to sel=2 sees in_ready=0 and is held. Offer to sel=1 is accepted.
- Drain/refill same cycle: channel 2 holds 4'hA, out_ready[2]=1 and in_data=4'h5 to sel=2 together → in_ready=1, next cycle out_valid[2]=1, out_data[11:8]=4'h5. Streaming 4 words back-to-back to sel=2 with out_ready[2]=1 completes in 4 cycles, with words received in order.
- Broadcast: in_bcast=1, in_data=4'h3 with channel 0 full and out_ready[0]=0 → in_ready=0. Raise out_ready[0] → accepted; next cycle out_valid=4'b1111, every slice=4'h3, in_count incremented by 1.
- Counter wrap with COUNT_WIDTH=3: 9 accepted transfers → in_count reads 1.
- Reset mid-operation: fill channels 0 and 3, assert reset 1 cycle → out_valid=0, in_count=0. First accept after reset to sel=0 delivers only the new word.
